vga_scan_timing: RTL and testbench
==================================

Name: vga_scan_timing

Overview:
- Generates raster scan timing (hsync, vsync, visible, pixel row/col) for the logistic-map display.
- Sits directly upstream of the colour-select logic, which consumes row/col and returns red/green/blue.
- Also emits a one-cycle frame_start pulse so the map iterators and the mu controller can resynchronise once per frame.
- Default timing is 640x480 at 60 Hz with a 25 MHz pixel rate; the pixel rate is derived from CLK via the CE input.

Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VIS, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_NEG, 1, 1 = sync pulses active-low

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous, active-low reset
- CE  in  1  pixel enable; counters and outputs advance only on CLK edges with CE=1
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- visible  out  1  high while the current pixel is in the active area
- col  out  10  horizontal pixel index, 0..H_total-1
- row  out  10  vertical line index, 0..V_total-1
- row_inv  out  10  V_VIS-1-row while visible, else 0
- frame_start  out  1  one-CLK pulse at the first pixel of each frame
- line_end  out  1  one-CLK pulse at the last pixel of each line

Behaviour:
- Derived totals: H_total = H_VIS+H_FP+H_SYNC+H_BP (800); V_total = V_VIS+V_FP+V_SYNC+V_BP (525).
- Counters hcnt and vcnt are 10 bits each.
- Counter stepping, on posedge CLK with CE=1:
  - hcnt increments; it wraps from H_total-1 to 0.
  - On that wrap, vcnt increments; it wraps from V_total-1 to 0.
  - When CE=0, counters hold.
- Output registers load, on each CE=1 edge, the decode of the pre-increment (hcnt, vcnt). All outputs therefore lag the counters by exactly one CE step.
- Decode rules (values shown for the defaults):
  - col = hcnt; row = vcnt.
  - visible = (hcnt < H_VIS) && (vcnt < V_VIS).
  - hsync is asserted while hcnt is in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1] = [656, 751].
  - vsync is asserted while vcnt is in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC-1] = [490, 491]. vsync is decoded from vcnt alone, so it spans whole lines.
  - Asserted level is 0 when SYNC_NEG=1; the deasserted level is the complement.
  - row_inv = V_VIS-1-vcnt when visible, otherwise 0.
- Pulses:
  - frame_start sets on the CE edge whose decoded count is (0, 0).
  - line_end sets on the CE edge whose decoded hcnt is H_total-1.
  - Both clear on the next CLK edge regardless of CE, so each lasts exactly one CLK cycle.
- Reset (RST=0, asynchronous), applied immediately and held while RST=0:
  - hcnt=0, vcnt=0, col=0, row=0, row_inv=0.
  - visible=0, frame_start=0, line_end=0.
  - hsync and vsync at their deasserted level (1 for the defaults).
- Reset release: the first CE=1 edge after release produces frame_start=1, visible=1, col=0, row=0, row_inv=479.
- Reset mid-frame aborts the frame; scanning restarts at (0, 0) with no partial-line state retained.
- CE held high permanently: one pixel per CLK.
- CE toggling irregularly: timing is counted in CE steps only. There is no minimum CE duty requirement.

Decomposition:
- Shared package vga_timing_pkg holds:
  - the default timing constants;
  - derived H_total and V_total;
  - a localparam pair for the sync polarity level.
- One natural sub-module, vga_axis_counter, instantiated twice (horizontal and vertical):
  - parameters: visible, front porch, sync and back porch widths;
  - inputs: step enable;
  - outputs: count, wrap, in_visible, in_sync.
  - The horizontal instance's wrap ANDed with CE drives the vertical instance's step.

Test Plan:
- Reset then CE=1 constant for 1 CLK → frame_start=1, visible=1, col=0, row=0, row_inv=479, hsync=1, vsync=1. Next cycle: frame_start=0, col=1.
- Run one full line → hsync=0 for exactly 96 consecutive CE steps beginning at col=656. line_end pulses once with col=799. The next step shows col=0, row=1.
- Run a full frame → vsync=0 for exactly 1600 steps (rows 490–491). visible is high for exactly 307200 steps. frame_start recurs 420000 steps later.
- CE asserted every 2nd CLK → outputs change only on CE edges. frame_start is still one CLK wide. The frame period is 840000 CLK cycles.
- Assert RST=0 asynchronously at row=300, col=400 between clock edges → outputs go to reset values before the next edge. After release, the first CE edge yields frame_start=1 with col=0, row=0.
- Boundary decode → at col=639 row=479, visible=1 and row_inv=0. At col=640 visible=0. At row=480 col=0, visible=0 and row_inv=0.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared raster timing constants and sync polarity helpers
package vga_timing_pkg;

  localparam int CNT_W = 10;

  localparam int DEF_H_VIS    = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_VIS    = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_SYNC_NEG = 1;

  localparam int DEF_H_TOTAL = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_VIS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam logic SYNC_ACTIVE_LVL = (DEF_SYNC_NEG != 0) ? 1'b0 : 1'b1;
  localparam logic SYNC_IDLE_LVL   = ~SYNC_ACTIVE_LVL;

  // Maps a logical "sync asserted" flag onto the pin level for a given polarity.
  function automatic logic sync_level(input int sync_neg, input logic asserted);
    return (sync_neg != 0) ? ~asserted : asserted;
  endfunction

endpackage

// File: rtl/vga_scan_timing_if.sv
// rtl/vga_scan_timing_if.sv - scan timing outputs bundle towards the colour-select logic
interface vga_scan_timing_if;
  import vga_timing_pkg::*;

  logic             hsync;
  logic             vsync;
  logic             visible;
  logic [CNT_W-1:0] col;
  logic [CNT_W-1:0] row;
  logic [CNT_W-1:0] row_inv;
  logic             frame_start;
  logic             line_end;

  modport master (
    output hsync, vsync, visible, col, row, row_inv, frame_start, line_end
  );

  modport slave (
    input hsync, vsync, visible, col, row, row_inv, frame_start, line_end
  );

endinterface

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: wrapping position counter with region decode
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int VIS  = DEF_H_VIS,
  parameter int FP   = DEF_H_FP,
  parameter int SYNC = DEF_H_SYNC,
  parameter int BP   = DEF_H_BP
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_step,
  output logic [CNT_W-1:0] o_count,
  output logic             o_wrap,
  output logic             o_in_visible,
  output logic             o_in_sync
);

  localparam int               L_TOTAL   = VIS + FP + SYNC + BP;
  localparam logic [CNT_W-1:0] L_LAST    = CNT_W'(L_TOTAL - 1);
  localparam logic [CNT_W-1:0] L_VIS     = CNT_W'(VIS);
  localparam logic [CNT_W-1:0] L_SYNC_LO = CNT_W'(VIS + FP);
  localparam logic [CNT_W-1:0] L_SYNC_HI = CNT_W'(VIS + FP + SYNC - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_step) begin
      r_count <= (r_count == L_LAST) ? '0 : r_count + 1'b1;
    end
  end

  // o_wrap flags the terminal count; the caller qualifies it with its own step.
  assign o_count      = r_count;
  assign o_wrap       = (r_count == L_LAST);
  assign o_in_visible = (r_count < L_VIS);
  assign o_in_sync    = (r_count >= L_SYNC_LO) && (r_count <= L_SYNC_HI);

endmodule

// File: rtl/vga_scan_timing.sv
// rtl/vga_scan_timing.sv - raster scan timing generator with per-frame and per-line pulses
module vga_scan_timing
  import vga_timing_pkg::*;
#(
  parameter int H_VIS    = DEF_H_VIS,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_VIS    = DEF_V_VIS,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int SYNC_NEG = DEF_SYNC_NEG
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               CE,
  vga_scan_timing_if.master  vid
);

  localparam logic             L_SYNC_IDLE = sync_level(SYNC_NEG, 1'b0);
  localparam logic [CNT_W-1:0] L_ROW_TOP   = CNT_W'(V_VIS - 1);

  logic [CNT_W-1:0] w_hcnt;
  logic [CNT_W-1:0] w_vcnt;
  logic             w_h_wrap;
  logic             w_unused_v_wrap;
  logic             w_h_vis;
  logic             w_v_vis;
  logic             w_h_sync;
  logic             w_v_sync;
  logic             w_visible;

  vga_axis_counter #(
    .VIS (H_VIS),
    .FP  (H_FP),
    .SYNC(H_SYNC),
    .BP  (H_BP)
  ) u_h_axis (
    .i_clk       (CLK),
    .i_rst_n     (RST),
    .i_step      (CE),
    .o_count     (w_hcnt),
    .o_wrap      (w_h_wrap),
    .o_in_visible(w_h_vis),
    .o_in_sync   (w_h_sync)
  );

  vga_axis_counter #(
    .VIS (V_VIS),
    .FP  (V_FP),
    .SYNC(V_SYNC),
    .BP  (V_BP)
  ) u_v_axis (
    .i_clk       (CLK),
    .i_rst_n     (RST),
    .i_step      (CE && w_h_wrap),
    .o_count     (w_vcnt),
    .o_wrap      (w_unused_v_wrap),
    .o_in_visible(w_v_vis),
    .o_in_sync   (w_v_sync)
  );

  assign w_visible = w_h_vis && w_v_vis;

  logic             r_hsync;
  logic             r_vsync;
  logic             r_visible;
  logic [CNT_W-1:0] r_col;
  logic [CNT_W-1:0] r_row;
  logic [CNT_W-1:0] r_row_inv;
  logic             r_frame_start;
  logic             r_line_end;

  // Outputs register the decode of the pre-increment counts, so they trail the
  // counters by one CE step; pulses are rewritten every CLK to stay one CLK wide.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_hsync       <= L_SYNC_IDLE;
      r_vsync       <= L_SYNC_IDLE;
      r_visible     <= 1'b0;
      r_col         <= '0;
      r_row         <= '0;
      r_row_inv     <= '0;
      r_frame_start <= 1'b0;
      r_line_end    <= 1'b0;
    end else begin
      if (CE) begin
        r_hsync   <= sync_level(SYNC_NEG, w_h_sync);
        r_vsync   <= sync_level(SYNC_NEG, w_v_sync);
        r_visible <= w_visible;
        r_col     <= w_hcnt;
        r_row     <= w_vcnt;
        r_row_inv <= w_visible ? (L_ROW_TOP - w_vcnt) : '0;
      end
      r_frame_start <= CE && (w_hcnt == '0) && (w_vcnt == '0);
      r_line_end    <= CE && w_h_wrap;
    end
  end

  assign vid.hsync       = r_hsync;
  assign vid.vsync       = r_vsync;
  assign vid.visible     = r_visible;
  assign vid.col         = r_col;
  assign vid.row         = r_row;
  assign vid.row_inv     = r_row_inv;
  assign vid.frame_start = r_frame_start;
  assign vid.line_end    = r_line_end;

endmodule

// File: tb/tb_vga_scan_timing.sv
// tb/tb_vga_scan_timing.sv - bench for vga_scan_timing at default and reduced raster sizes
module tb_vga_scan_timing;

  localparam int SH_VIS = 16, SH_FP = 2, SH_SYNC = 4, SH_BP = 3;
  localparam int SV_VIS = 12, SV_FP = 2, SV_SYNC = 2, SV_BP = 3;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       vis;
    logic [9:0] col;
    logic [9:0] row;
    logic [9:0] rinv;
    logic       fs;
    logic       le;
  } exp_t;

  typedef struct {
    int   k;
    exp_t e;
  } vec_t;

  logic CLK = 1'b0;
  logic RST;
  logic CE;

  vga_scan_timing_if vid_d ();
  vga_scan_timing_if vid_s ();

  vga_scan_timing dut_d (
    .CLK(CLK),
    .RST(RST),
    .CE (CE),
    .vid(vid_d)
  );

  vga_scan_timing #(
    .H_VIS(SH_VIS), .H_FP(SH_FP), .H_SYNC(SH_SYNC), .H_BP(SH_BP),
    .V_VIS(SV_VIS), .V_FP(SV_FP), .V_SYNC(SV_SYNC), .V_BP(SV_BP),
    .SYNC_NEG(1)
  ) dut_s (
    .CLK(CLK),
    .RST(RST),
    .CE (CE),
    .vid(vid_s)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input bit hs, input bit vs, input bit vis, input int col,
                              input int row, input int rinv, input bit fs, input bit le);
    exp_t e;
    e.hs = hs; e.vs = vs; e.vis = vis;
    e.col = 10'(col); e.row = 10'(row); e.rinv = 10'(rinv);
    e.fs = fs; e.le = le;
    return e;
  endfunction

  // Reference: after k CE steps the outputs describe raster position k-1.
  function automatic exp_t model(input int hv, input int hfp, input int hsw, input int hbp,
                                 input int vv, input int vfp, input int vsw, input int vbp,
                                 input int k, input bit pulse);
    int ht, vt, pos, h, v;
    bit vis;
    ht = hv + hfp + hsw + hbp;
    vt = vv + vfp + vsw + vbp;
    if (k == 0) return mk(1, 1, 0, 0, 0, 0, 0, 0);
    pos = (k - 1) % (ht * vt);
    h = pos % ht;
    v = pos / ht;
    vis = (h < hv) && (v < vv);
    return mk(!(h >= hv + hfp && h < hv + hfp + hsw),
              !(v >= vv + vfp && v < vv + vfp + vsw),
              vis, h, v, vis ? (vv - 1 - v) : 0,
              pulse && (pos == 0), pulse && (h == ht - 1));
  endfunction

  int k;
  bit pulse;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      k     <= 0;
      pulse <= 1'b0;
    end else begin
      if (CE) k <= k + 1;
      pulse <= CE;
    end
  end

  exp_t a_s, a_d;
  assign a_s = {vid_s.hsync, vid_s.vsync, vid_s.visible, vid_s.col, vid_s.row,
                vid_s.row_inv, vid_s.frame_start, vid_s.line_end};
  assign a_d = {vid_d.hsync, vid_d.vsync, vid_d.visible, vid_d.col, vid_d.row,
                vid_d.row_inv, vid_d.frame_start, vid_d.line_end};

  bit mon_en = 1'b0;

  always @(negedge CLK) begin
    if (mon_en) begin
      chk("model_small", a_s, model(SH_VIS, SH_FP, SH_SYNC, SH_BP, SV_VIS, SV_FP, SV_SYNC, SV_BP, k, pulse));
      chk("model_default", a_d, model(640, 16, 96, 48, 480, 10, 2, 33, k, pulse));
    end
  end

  vec_t tbl[$];

  initial begin
    int idx;
    int s_vs, s_vis, s_fs_n, s_fs_k1, s_fs_k2;
    int d_hs_n, d_hs_first, d_le_n, d_le_col;
    int fs_clk1, fs_clk2, fs_seen, fs_wide;
    bit prev_fs;

    tbl.push_back('{1,   mk(1, 1, 1, 0,  0,  11, 1, 0)});
    tbl.push_back('{2,   mk(1, 1, 1, 1,  0,  11, 0, 0)});
    tbl.push_back('{16,  mk(1, 1, 1, 15, 0,  11, 0, 0)});
    tbl.push_back('{17,  mk(1, 1, 0, 16, 0,  0,  0, 0)});
    tbl.push_back('{18,  mk(1, 1, 0, 17, 0,  0,  0, 0)});
    tbl.push_back('{19,  mk(0, 1, 0, 18, 0,  0,  0, 0)});
    tbl.push_back('{22,  mk(0, 1, 0, 21, 0,  0,  0, 0)});
    tbl.push_back('{23,  mk(1, 1, 0, 22, 0,  0,  0, 0)});
    tbl.push_back('{25,  mk(1, 1, 0, 24, 0,  0,  0, 1)});
    tbl.push_back('{26,  mk(1, 1, 1, 0,  1,  10, 0, 0)});
    tbl.push_back('{291, mk(1, 1, 1, 15, 11, 0,  0, 0)});
    tbl.push_back('{292, mk(1, 1, 0, 16, 11, 0,  0, 0)});
    tbl.push_back('{301, mk(1, 1, 0, 0,  12, 0,  0, 0)});
    tbl.push_back('{350, mk(1, 1, 0, 24, 13, 0,  0, 1)});
    tbl.push_back('{351, mk(1, 0, 0, 0,  14, 0,  0, 0)});
    tbl.push_back('{370, mk(0, 0, 0, 19, 14, 0,  0, 0)});
    tbl.push_back('{400, mk(1, 0, 0, 24, 15, 0,  0, 1)});
    tbl.push_back('{401, mk(1, 1, 0, 0,  16, 0,  0, 0)});
    tbl.push_back('{475, mk(1, 1, 0, 24, 18, 0,  0, 1)});
    tbl.push_back('{476, mk(1, 1, 1, 0,  0,  11, 1, 0)});

    RST = 1'b1;
    CE  = 1'b0;
    #1 RST = 1'b0;
    mon_en = 1'b1;
    @(negedge CLK);
    CE = 1'b1;
    repeat (3) @(negedge CLK);
    chk("reset_small", a_s, mk(1, 1, 0, 0, 0, 0, 0, 0));
    chk("reset_default", a_d, mk(1, 1, 0, 0, 0, 0, 0, 0));
    RST = 1'b1;

    // Constant CE: walk the vector table on the small raster and gather line/frame stats.
    idx = 0;
    s_vs = 0; s_vis = 0; s_fs_n = 0; s_fs_k1 = 0; s_fs_k2 = 0;
    d_hs_n = 0; d_hs_first = -1; d_le_n = 0; d_le_col = -1;
    for (int c = 0; c < 1700; c++) begin
      @(negedge CLK);
      if (idx < tbl.size() && k == tbl[idx].k) begin
        chk($sformatf("vec_k%0d", tbl[idx].k), a_s, tbl[idx].e);
        idx++;
      end
      if (k >= 1 && k <= 475) begin
        if (!vid_s.vsync) s_vs++;
        if (vid_s.visible) s_vis++;
      end
      if (vid_s.frame_start) begin
        s_fs_n++;
        if (s_fs_n == 1) s_fs_k1 = k;
        if (s_fs_n == 2) s_fs_k2 = k;
      end
      if (k >= 1 && k <= 800) begin
        if (!vid_d.hsync) begin
          if (d_hs_n == 0) d_hs_first = int'(vid_d.col);
          d_hs_n++;
        end
        if (vid_d.line_end) begin
          d_le_n++;
          d_le_col = int'(vid_d.col);
        end
      end
      if (k == 801) begin
        chk("default_next_line_col", vid_d.col, 0);
        chk("default_next_line_row", vid_d.row, 1);
      end
    end
    chk("table_reached", idx, tbl.size());
    chk("small_vsync_steps", s_vs, SV_SYNC * 25);
    chk("small_visible_steps", s_vis, SH_VIS * SV_VIS);
    chk("small_frame_steps", s_fs_k2 - s_fs_k1, 25 * 19);
    chk("default_hsync_steps", d_hs_n, 96);
    chk("default_hsync_first_col", d_hs_first, 656);
    chk("default_line_end_count", d_le_n, 1);
    chk("default_line_end_col", d_le_col, 799);

    // CE on every second CLK: frame period doubles and pulses stay one CLK wide.
    fs_clk1 = 0; fs_clk2 = 0; fs_seen = 0; fs_wide = 0; prev_fs = 1'b0;
    for (int c = 0; c < 2200; c++) begin
      @(negedge CLK);
      if (vid_s.frame_start) begin
        if (prev_fs) fs_wide++;
        fs_seen++;
        if (fs_seen == 1) fs_clk1 = c;
        if (fs_seen == 2) fs_clk2 = c;
      end
      prev_fs = vid_s.frame_start;
      CE = ~CE;
    end
    chk("half_rate_fs_seen", fs_seen >= 2, 1);
    chk("half_rate_frame_clks", fs_clk2 - fs_clk1, 2 * 25 * 19);
    chk("half_rate_fs_wide", fs_wide, 0);

    // Irregular CE with an asynchronous reset dropped between clock edges.
    for (int c = 0; c < 1500; c++) begin
      @(negedge CLK);
      CE = 1'($urandom_range(0, 1));
      if (c == 700) begin
        chk("pre_reset_mid_frame", (a_s.col != 0) || (a_s.row != 0), 1);
        @(posedge CLK);
        #2 RST = 1'b0;
        #1;
        chk("async_reset_small", a_s, mk(1, 1, 0, 0, 0, 0, 0, 0));
        chk("async_reset_default", a_d, mk(1, 1, 0, 0, 0, 0, 0, 0));
        @(negedge CLK);
        CE = 1'b1;
        repeat (2) @(negedge CLK);
        chk("reset_hold_small", a_s, mk(1, 1, 0, 0, 0, 0, 0, 0));
        RST = 1'b1;
        @(negedge CLK);
        chk("release_small", a_s, mk(1, 1, 1, 0, 0, 11, 1, 0));
        chk("release_default", a_d, mk(1, 1, 1, 0, 0, 479, 1, 0));
      end
    end

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
